// File: rtl/alu_entry_sequencer.sv
// alu_entry_sequencer: debounced two-button entry FSM that loads operands A and B,
// commits an ALU op code and flags the result display.
module alu_entry_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw_n,
    output logic o_press
);
    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] r_sync;
    logic       r_level;
    logic       r_level_q;
    logic [7:0] r_cnt;
    logic       r_press;
    logic       w_s;

    assign w_s     = r_sync[1];
    assign o_press = r_press;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync    <= 2'b11;
            r_level   <= 1'b1;
            r_level_q <= 1'b1;
            r_cnt     <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_raw_n};
            r_level_q <= r_level;
            // Only a settled high-to-low level change is a press; releases are silent.
            r_press   <= r_level_q & ~r_level;
            if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end
endmodule

module alu_entry_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_btn_enter_n,
    input  logic       i_btn_clear_n,
    input  logic [3:0] i_data_in,
    output logic       o_save_a_n,
    output logic       o_save_b_n,
    output logic [2:0] o_op_sel,
    output logic       o_alu_go,
    output logic       o_result_valid,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        SHOW    = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_save_a_n;
    logic       r_save_b_n;
    logic [2:0] r_op_sel;
    logic       r_alu_go;
    logic       r_result_valid;
    logic       w_save_a_n;
    logic       w_save_b_n;
    logic [2:0] w_op_sel;
    logic       w_alu_go;
    logic       w_result_valid;
    logic       w_press_enter;
    logic       w_press_clear;
    logic       w_unused;

    assign w_unused = i_data_in[3];

    alu_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw_n (i_btn_enter_n),
        .o_press (w_press_enter)
    );

    alu_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw_n (i_btn_clear_n),
        .o_press (w_press_clear)
    );

    always_comb begin
        w_next_state   = r_state;
        w_save_a_n     = 1'b1;
        w_save_b_n     = 1'b1;
        w_alu_go       = 1'b0;
        w_op_sel       = r_op_sel;
        w_result_valid = r_result_valid;
        // Clear has priority so a simultaneous enter never leaks a strobe.
        if (w_press_clear) begin
            w_next_state   = LOAD_A;
            w_op_sel       = 3'd0;
            w_result_valid = 1'b0;
        end else if (w_press_enter) begin
            case (r_state)
                LOAD_A: begin
                    w_save_a_n   = 1'b0;
                    w_next_state = LOAD_B;
                end
                LOAD_B: begin
                    w_save_b_n   = 1'b0;
                    w_next_state = LOAD_OP;
                end
                LOAD_OP: begin
                    w_op_sel       = i_data_in[2:0];
                    w_alu_go       = 1'b1;
                    w_result_valid = 1'b1;
                    w_next_state   = SHOW;
                end
                SHOW: begin
                    w_result_valid = 1'b0;
                    w_next_state   = LOAD_A;
                end
                default: w_next_state = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= LOAD_A;
            r_save_a_n     <= 1'b1;
            r_save_b_n     <= 1'b1;
            r_op_sel       <= 3'd0;
            r_alu_go       <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_save_a_n     <= w_save_a_n;
            r_save_b_n     <= w_save_b_n;
            r_op_sel       <= w_op_sel;
            r_alu_go       <= w_alu_go;
            r_result_valid <= w_result_valid;
        end
    end

    assign o_save_a_n     = r_save_a_n;
    assign o_save_b_n     = r_save_b_n;
    assign o_op_sel       = r_op_sel;
    assign o_alu_go       = r_alu_go;
    assign o_result_valid = r_result_valid;
    assign o_state        = r_state;
endmodule

// File: tb/tb_alu_entry_sequencer.sv
// tb_alu_entry_sequencer: random and directed button stimulus checked every cycle
// against a behavioural model of the entry sequencer.
module tb_alu_entry_sequencer;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ben = 1'b1;
    logic       bcl = 1'b1;
    logic [3:0] din = 4'd0;
    logic       o_save_a_n;
    logic       o_save_b_n;
    logic [2:0] o_op_sel;
    logic       o_alu_go;
    logic       o_result_valid;
    logic [1:0] o_state;

    int n_cmp = 0;
    int n_bad = 0;

    alu_entry_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_btn_enter_n  (ben),
        .i_btn_clear_n  (bcl),
        .i_data_in      (din),
        .o_save_a_n     (o_save_a_n),
        .o_save_b_n     (o_save_b_n),
        .o_op_sel       (o_op_sel),
        .o_alu_go       (o_alu_go),
        .o_result_valid (o_result_valid),
        .o_state        (o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Behavioural model: a button's level flips once its synchronized sample has held
    // the opposite value for D consecutive clocks; a press is reported one clock after
    // a falling flip and acted on by the sequencer one clock later.
    logic       m_s1[2], m_s[2], m_lvl[2], m_last[2], m_fell[2], m_press[2];
    int         m_run[2];
    int         m_st;
    logic       m_rv;
    logic [2:0] m_op;
    logic       e_a, e_b, e_go;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1; m_s[b] = 1; m_lvl[b] = 1; m_last[b] = 1;
            m_fell[b] = 0; m_press[b] = 0; m_run[b] = 0;
        end
        m_st = 0; m_rv = 0; m_op = 0; e_a = 1; e_b = 1; e_go = 0;
    endtask

    task automatic model_step();
        logic raw[2];
        logic p_en, p_cl;
        raw[0] = ben;
        raw[1] = bcl;
        p_en = m_press[0];
        p_cl = m_press[1];
        e_a = 1; e_b = 1; e_go = 0;
        if (p_cl) begin
            m_st = 0; m_rv = 0; m_op = 0;
        end else if (p_en) begin
            if (m_st == 0) e_a = 0;
            if (m_st == 1) e_b = 0;
            if (m_st == 2) begin e_go = 1; m_op = din[2:0]; end
            m_rv = (m_st == 2);
            m_st = (m_st + 1) % 4;
        end
        for (int b = 0; b < 2; b++) begin
            logic fell;
            m_run[b] = (m_s[b] == m_last[b]) ? m_run[b] + 1 : 1;
            m_last[b] = m_s[b];
            fell = 0;
            if (m_s[b] != m_lvl[b] && m_run[b] >= D) begin
                fell = (m_s[b] == 0);
                m_lvl[b] = m_s[b];
            end
            m_press[b] = m_fell[b];
            m_fell[b] = fell;
            m_s[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            else model_step();
            chk("cycle_outputs",
                {o_save_a_n, o_save_b_n, o_op_sel, o_alu_go, o_result_valid, o_state},
                {e_a, e_b, m_op, e_go, m_rv, 2'(m_st)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_btn(input logic en, input logic cl, input logic [3:0] d,
                             output int first_a, output int n_a, output int n_b, output int n_go);
        first_a = -1; n_a = 0; n_b = 0; n_go = 0;
        din = d;
        ben = ~en;
        bcl = ~cl;
        for (int i = 1; i <= 28; i++) begin
            cyc(1);
            if (!o_save_a_n) begin n_a++; if (first_a < 0) first_a = i; end
            if (!o_save_b_n) n_b++;
            if (o_alu_go) n_go++;
            if (i == 10) begin ben = 1; bcl = 1; end
        end
    endtask

    int fa, na, nb, ng;

    initial begin
        cyc(3);
        chk("reset_outputs", {o_save_a_n, o_save_b_n, o_op_sel, o_alu_go, o_result_valid, o_state},
            9'b1_1_000_0_0_00);
        reset_n = 1;
        cyc(2);

        press_btn(1, 0, 4'd5, fa, na, nb, ng);
        chk("latency_a", 9'(fa), 9'd8);
        chk("pulses_a", 9'(na), 9'd1);
        chk("state_after_a", 9'(o_state), 9'd1);
        press_btn(1, 0, 4'd3, fa, na, nb, ng);
        chk("pulses_b", {5'(na), 4'(nb)}, {5'd0, 4'd1});
        chk("state_after_b", 9'(o_state), 9'd2);
        press_btn(1, 0, 4'b1110, fa, na, nb, ng);
        chk("pulses_go", 9'(ng), 9'd1);
        chk("commit", {o_op_sel, o_result_valid, o_state}, {3'b110, 1'b1, 2'b11});
        press_btn(1, 0, 4'd0, fa, na, nb, ng);
        chk("show_exit", {o_op_sel, o_result_valid, o_state, 3'(na + nb + ng)},
            {3'b110, 1'b0, 2'b00, 3'd0});

        ben = 0; cyc(3); ben = 1;
        na = 0;
        for (int i = 0; i < 20; i++) begin cyc(1); if (!o_save_a_n) na++; end
        chk("glitch_no_strobe", {7'(na), o_state}, {7'd0, 2'b00});
        press_btn(1, 0, 4'd0, fa, na, nb, ng);
        chk("clean_press_once", {7'(na), o_state}, {7'd1, 2'b01});

        press_btn(1, 0, 4'd0, fa, na, nb, ng);
        press_btn(1, 0, 4'd2, fa, na, nb, ng);
        press_btn(1, 0, 4'd0, fa, na, nb, ng);
        press_btn(1, 0, 4'd0, fa, na, nb, ng);
        press_btn(1, 0, 4'd0, fa, na, nb, ng);
        chk("load_op_held", {o_op_sel, o_state}, {3'd2, 2'b10});
        press_btn(0, 1, 4'd7, fa, na, nb, ng);
        chk("clear", {o_op_sel, o_state, 3'(na + nb + ng)}, {3'd0, 2'b00, 3'd0});

        press_btn(1, 0, 4'd0, fa, na, nb, ng);
        press_btn(1, 1, 4'd0, fa, na, nb, ng);
        chk("simultaneous", {o_state, 7'(nb)}, {2'b00, 7'd0});

        ben = 0; cyc(D + 3);
        reset_n = 0; cyc(1);
        chk("reset_mid_press", {o_save_a_n, o_state}, {1'b1, 2'b00});
        reset_n = 1; ben = 1; cyc(15);

        reset_n = 0; ben = 0; cyc(3);
        reset_n = 1;
        fa = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (!o_save_a_n && fa < 0) fa = i;
            if (i == 12) ben = 1;
        end
        chk("held_through_reset", 9'(fa), 9'(D + 4));

        for (int k = 0; k < 200; k++) begin
            int r;
            r = $urandom_range(0, 9);
            din = 4'($urandom);
            if (r == 9) begin
                reset_n = 0; cyc($urandom_range(1, 3)); reset_n = 1;
            end else begin
                ben = !(r <= 5 || r == 7);
                bcl = !(r == 6 || r == 7);
                cyc((r == 8) ? $urandom_range(1, 3) : $urandom_range(1, 12));
                ben = 1; bcl = 1;
            end
            cyc($urandom_range(1, 14));
        end
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
